// File: rtl/l1_mem_arbiter.sv
// rtl/l1_mem_arbiter.sv - round-robin N-port L1 requestor arbiter onto one single-ported backing memory
//
// Ports (per-port buses flattened, port i at slice [i*W +: W]):
//   clk, reset                  clock and synchronous active-high reset
//   read_en, write_en           per-port request; write wins when both are set
//   addr, write_mask, write_data per-port request payload, held by the requestor while stalled
//   read_data, stall            per-port response; stall low marks the completing cycle
//   mem_req/we/addr/wmask/wdata backing-memory request, stable while BUSY
//   mem_ack, mem_rdata          backing-memory completion (may arrive in the first BUSY cycle)
//   grant_cnt, conflict_cnt     saturating statistics counters
// Optional feature: define ARB_STATS_EN to build the statistics counters;
// otherwise grant_cnt and conflict_cnt are tied to zero.
module l1_mem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_PORTS-1:0]                read_en,
  input  logic [NUM_PORTS-1:0]                write_en,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     addr,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] write_mask,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     write_data,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]     read_data,
  output logic [NUM_PORTS-1:0]                stall,
  output logic                                mem_req,
  output logic                                mem_we,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  output logic [DATA_WIDTH/8-1:0]             mem_wmask,
  output logic [DATA_WIDTH-1:0]               mem_wdata,
  input  logic                                mem_ack,
  input  logic [DATA_WIDTH-1:0]               mem_rdata,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]      grant_cnt,
  output logic [CNT_WIDTH-1:0]                conflict_cnt
);

  localparam int MW = DATA_WIDTH / 8;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nx;
  logic [PW-1:0]        rr_ptr, grant, winner;
  logic [NUM_PORTS-1:0] req;
  logic                 any_req;
  logic                 done;
  int                   idx;
  logic [DATA_WIDTH-1:0] rd_q [NUM_PORTS];

  assign req     = read_en | write_en;
  assign mem_req = (state == BUSY);
  // An ack only counts while a transaction is actually outstanding.
  assign done    = (state == BUSY) && mem_ack;

  // First requesting port at or after rr_ptr, scanning cyclically.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_PORTS;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = PW'(idx);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = BUSY;
      BUSY:    if (mem_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wmask <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        grant     <= winner;
        mem_we    <= write_en[winner];
        mem_addr  <= addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wmask <= write_mask[winner*MW +: MW];
        mem_wdata <= write_data[winner*DATA_WIDTH +: DATA_WIDTH];
      end
      if (done) begin
        mem_we <= 1'b0;
        rr_ptr <= (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

  // Read data is captured even if the requestor has already dropped its request.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) rd_q[p] <= '0;
    end else if (done && !mem_we) begin
      rd_q[grant] <= mem_rdata;
    end
  end

  always_comb begin
    read_data = '0;
    stall     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      read_data[p*DATA_WIDTH +: DATA_WIDTH] =
        (done && !mem_we && grant == PW'(p)) ? mem_rdata : rd_q[p];
      stall[p] = req[p] & ~(done && grant == PW'(p));
    end
  end

`ifdef ARB_STATS_EN
  logic [CNT_WIDTH-1:0] gcnt [NUM_PORTS];
  logic [CNT_WIDTH-1:0] ccnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) gcnt[p] <= '0;
      ccnt <= '0;
    end else begin
      if (done && gcnt[grant] != '1) gcnt[grant] <= gcnt[grant] + 1'b1;
      if (state == IDLE && $countones(req) > 1 && ccnt != '1) ccnt <= ccnt + 1'b1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int p = 0; p < NUM_PORTS; p++) grant_cnt[p*CNT_WIDTH +: CNT_WIDTH] = gcnt[p];
  end
  assign conflict_cnt = ccnt;
`else
  assign grant_cnt    = '0;
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb/tb_l1_mem_arbiter.sv - scoreboard bench for l1_mem_arbiter (3 ports, 32-bit)
module tb_l1_mem_arbiter;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     read_en, write_en;
  logic [NP*AW-1:0]  addr;
  logic [NP*4-1:0]   write_mask;
  logic [NP*DW-1:0]  write_data;
  logic [NP*DW-1:0]  read_data;
  logic [NP-1:0]     stall;
  logic              mem_req, mem_we, mem_ack;
  logic [AW-1:0]     mem_addr;
  logic [3:0]        mem_wmask;
  logic [DW-1:0]     mem_wdata, mem_rdata;
  logic [NP*CW-1:0]  grant_cnt;
  logic [CW-1:0]     conflict_cnt;

  l1_mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .read_en(read_en), .write_en(write_en), .addr(addr),
    .write_mask(write_mask), .write_data(write_data), .read_data(read_data), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .grant_cnt(grant_cnt), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] a;
    logic [3:0]  m;
    logic [31:0] wd;
    logic [31:0] rd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ack_delay = 0;
  bit   resp_en = 1'b1;
  logic force_ack = 1'b0;
  logic [31:0] force_rdata = '0;
  int   busy_cnt = 0;
  int   stall_log [NP][8];
  int   sc;

  function automatic logic [31:0] model(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {~a[15:0], a[15:0]};
  endfunction

  function automatic exp_t mk(input int p, input logic we, input logic [31:0] a,
                              input logic [3:0] m, input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    e.port = p; e.we = we; e.a = a; e.m = m; e.wd = wd; e.rd = rd;
    return e;
  endfunction

  function automatic logic [31:0] rdp(input int p);
    return read_data[p*DW +: DW];
  endfunction

  function automatic logic [15:0] gcp(input int p);
    return grant_cnt[p*CW +: CW];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Backing-memory responder: acks after ack_delay BUSY cycles.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        mem_ack = force_ack;
        mem_rdata = force_rdata;
      end else if (mem_req) begin
        mem_ack = (busy_cnt >= ack_delay);
        mem_rdata = model(mem_addr);
        busy_cnt++;
      end else begin
        mem_ack = 1'b0;
        busy_cnt = 0;
      end
    end
  end

  // Monitor: every completing backing-memory access is matched against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset && mem_req && mem_ack) begin
        if (q.size() == 0) begin
          chk("unexpected_txn", {32'h0, mem_addr}, 64'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("mem_addr", mem_addr, e.a);
          chk("mem_we", mem_we, e.we);
          chk("stall_on_ack", stall[e.port], 1'b0);
          chk("read_data", rdp(e.port), e.rd);
          if (e.we) begin
            chk("mem_wmask", mem_wmask, e.m);
            chk("mem_wdata", mem_wdata, e.wd);
          end
        end
      end
    end
  end

  task automatic run_txn(input int p, input logic we, input logic re, input logic [31:0] a,
                         input logic [3:0] m, input logic [31:0] d, input bit last,
                         output int stalls);
    bit done;
    @(posedge clk); #1;
    read_en[p] = re;
    write_en[p] = we;
    addr[p*AW +: AW] = a;
    write_mask[p*4 +: 4] = m;
    write_data[p*DW +: DW] = d;
    stalls = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk); #2;
      if (stall[p]) stalls++;
      else done = 1'b1;
    end
    if (!done) chk("txn_timeout", 64'd0, 64'd1);
    if (last) begin
      @(posedge clk); #1;
      read_en[p] = 1'b0;
      write_en[p] = 1'b0;
    end
  endtask

  task automatic run_port(input int p, input int n, input logic [31:0] base);
    int s;
    for (int k = 0; k < n; k++) begin
      run_txn(p, 1'b0, 1'b1, base + 32'(16 * k), 4'hF, 32'h0, (k == n - 1), s);
      stall_log[p][k] = s;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    read_en = '0; write_en = '0; addr = '0; write_mask = '0; write_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_stall", stall, 3'b000);
    chk("rst_read_data", read_data, 96'h0);
    chk("rst_grant_cnt", grant_cnt, 48'h0);
    chk("rst_conflict_cnt", conflict_cnt, 16'h0);

    // Single read, ack one cycle after mem_req.
    ack_delay = 1;
    q.push_back(mk(0, 1'b0, 32'h100, 4'h0, 32'h0, 32'hDEADBEEF));
    run_txn(0, 1'b0, 1'b1, 32'h100, 4'hF, 32'h0, 1'b1, sc);
    chk("single_read_stall_cycles", sc, 2);
    @(negedge clk);
    chk("read_data0_held", rdp(0), 32'hDEADBEEF);

    // Masked write from port 1.
    ack_delay = 2;
    q.push_back(mk(1, 1'b1, 32'h40, 4'b0011, 32'h11223344, 32'h0));
    run_txn(1, 1'b1, 1'b0, 32'h40, 4'b0011, 32'h11223344, 1'b1, sc);
    chk("masked_write_stall_cycles", sc, 3);

    // Read and write together on port 0: treated as a write.
    ack_delay = 0;
    q.push_back(mk(0, 1'b1, 32'h80, 4'hF, 32'hCAFEF00D, 32'hDEADBEEF));
    run_txn(0, 1'b1, 1'b1, 32'h80, 4'hF, 32'hCAFEF00D, 1'b1, sc);
    chk("rw_stall_cycles", sc, 1);
    @(negedge clk);
    chk("rw_read_data0_unchanged", rdp(0), 32'hDEADBEEF);

    // Reset while BUSY, then a stray ack in IDLE.
    resp_en = 1'b0;
    force_ack = 1'b0;
    @(posedge clk); #1;
    read_en[0] = 1'b1;
    addr[0 +: AW] = 32'h300;
    @(posedge clk); #1;
    chk("busy_before_reset", mem_req, 1'b1);
    chk("stall_before_reset", stall[0], 1'b1);
    reset = 1'b1;
    read_en[0] = 1'b0;
    @(posedge clk); #1;
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_read_data0", rdp(0), 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    reset = 1'b0;
    force_ack = 1'b1;
    force_rdata = 32'h12345678;
    @(posedge clk); #1;
    chk("idle_ack_mem_req", mem_req, 1'b0);
    force_ack = 1'b0;
    @(posedge clk); #1;
    chk("idle_ack_mem_req_after", mem_req, 1'b0);
    chk("idle_ack_read_data0", rdp(0), 32'h0);
    resp_en = 1'b1;
    q.push_back(mk(0, 1'b0, 32'h310, 4'h0, 32'h0, 32'hFCEF0310));
    q.push_back(mk(1, 1'b0, 32'h320, 4'h0, 32'h0, 32'hFCDF0320));
    fork
      run_port(0, 1, 32'h310);
      run_port(1, 1, 32'h320);
    join
    chk("post_reset_queue_empty", q.size(), 0);

    // Two-port contention with same-cycle ack.
    do_reset();
    ack_delay = 0;
    q.push_back(mk(0, 1'b0, 32'h200, 4'h0, 32'h0, 32'hFDFF0200));
    q.push_back(mk(1, 1'b0, 32'h400, 4'h0, 32'h0, 32'hFBFF0400));
    q.push_back(mk(0, 1'b0, 32'h210, 4'h0, 32'h0, 32'hFDEF0210));
    q.push_back(mk(1, 1'b0, 32'h410, 4'h0, 32'h0, 32'hFBEF0410));
    q.push_back(mk(0, 1'b0, 32'h220, 4'h0, 32'h0, 32'hFDDF0220));
    fork
      run_port(0, 3, 32'h200);
      run_port(1, 2, 32'h400);
    join
    chk("contention_queue_empty", q.size(), 0);
    chk("contention_p1_txn0_stalls", stall_log[1][0], 3);
    chk("contention_p1_txn1_stalls", stall_log[1][1], 3);
`ifdef ARB_STATS_EN
    chk("contention_grant_cnt0", gcp(0), 16'd3);
    chk("contention_grant_cnt1", gcp(1), 16'd2);
    chk("contention_conflict_cnt", conflict_cnt, 16'd4);
`else
    chk("contention_grant_cnt_off", grant_cnt, 48'h0);
    chk("contention_conflict_cnt_off", conflict_cnt, 16'h0);
`endif

    // Three ports: port 2 joins one cycle late while ports 0 and 1 saturate.
    do_reset();
    q.push_back(mk(0, 1'b0, 32'h500, 4'h0, 32'h0, 32'hFAFF0500));
    q.push_back(mk(1, 1'b0, 32'h600, 4'h0, 32'h0, 32'hF9FF0600));
    q.push_back(mk(2, 1'b0, 32'h700, 4'h0, 32'h0, 32'hF8FF0700));
    q.push_back(mk(0, 1'b0, 32'h510, 4'h0, 32'h0, 32'hFAEF0510));
    q.push_back(mk(1, 1'b0, 32'h610, 4'h0, 32'h0, 32'hF9EF0610));
    q.push_back(mk(0, 1'b0, 32'h520, 4'h0, 32'h0, 32'hFADF0520));
    q.push_back(mk(1, 1'b0, 32'h620, 4'h0, 32'h0, 32'hF9DF0620));
    q.push_back(mk(0, 1'b0, 32'h530, 4'h0, 32'h0, 32'hFACF0530));
    q.push_back(mk(1, 1'b0, 32'h630, 4'h0, 32'h0, 32'hF9CF0630));
    fork
      run_port(0, 4, 32'h500);
      run_port(1, 4, 32'h600);
      begin
        @(posedge clk);
        run_port(2, 1, 32'h700);
      end
    join
    chk("fair_queue_empty", q.size(), 0);
    chk("fair_p2_stall_cycles", stall_log[2][0], 4);
`ifdef ARB_STATS_EN
    chk("fair_grant_cnt0", gcp(0), 16'd4);
    chk("fair_grant_cnt1", gcp(1), 16'd4);
    chk("fair_grant_cnt2", gcp(2), 16'd1);
    chk("fair_conflict_cnt", conflict_cnt, 16'd8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
